// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory request/ack bus between fetch and imem
interface fetch_unit_if #(
   parameter int XLEN = 32
) ();
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ack;
   logic [XLEN-1:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC, imem handshake and DX pipeline register for the 3-stage core
module fetch_unit #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter logic [XLEN-1:0] NOP_INST = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall_if,
   input  logic            stall_dx,
   input  logic            flush_dx,
   input  logic            br_taken,
   input  logic [XLEN-1:0] br_target,
   fetch_unit_if.master    imem,
   output logic [XLEN-1:0] pc_dx,
   output logic [XLEN-1:0] inst_dx,
   output logic            valid_dx
);

   typedef enum logic [1:0] {FETCH, HOLD, KILL} state_t;

   state_t          state, state_n;
   logic [XLEN-1:0] pc_f, pc_n;
   logic [XLEN-1:0] addr_q;
   logic            req_q;
   logic [XLEN-1:0] buf_pc, buf_inst;
   logic            buf_load;
   logic [XLEN-1:0] cand_pc, cand_inst;
   logic            cand_valid;
   logic            ack;
   logic [XLEN-1:0] tgt;

   assign imem.imem_req  = req_q;
   assign imem.imem_addr = addr_q;

   // An ack with no request outstanding is not a transfer.
   assign ack = imem.imem_ack & req_q;
   assign tgt = br_target & ~XLEN'(3);

   always_comb begin
      state_n    = state;
      pc_n       = pc_f;
      buf_load   = 1'b0;
      cand_pc    = pc_f;
      cand_inst  = NOP_INST;
      cand_valid = 1'b0;
      case (state)
         FETCH: begin
            if (br_taken) begin
               pc_n = tgt;
               if (req_q && !ack) state_n = KILL;
            end else if (ack) begin
               if (stall_if) begin
                  buf_load = 1'b1;
                  state_n  = HOLD;
               end else begin
                  cand_inst  = imem.imem_rdata;
                  cand_valid = 1'b1;
                  pc_n       = pc_f + XLEN'(4);
               end
            end
         end
         HOLD: begin
            if (br_taken) begin
               pc_n    = tgt;
               state_n = FETCH;
            end else if (!stall_if) begin
               cand_pc    = buf_pc;
               cand_inst  = buf_inst;
               cand_valid = 1'b1;
               pc_n       = buf_pc + XLEN'(4);
               state_n    = FETCH;
            end
         end
         KILL: begin
            if (br_taken) pc_n = tgt;
            if (ack) state_n = FETCH;
         end
         default: state_n = FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= FETCH;
         pc_f     <= RESET_PC;
         req_q    <= 1'b0;
         addr_q   <= RESET_PC;
         buf_pc   <= '0;
         buf_inst <= NOP_INST;
      end else begin
         state <= state_n;
         pc_f  <= pc_n;
         req_q <= (state_n != HOLD);
         // KILL keeps presenting the abandoned address until its ack drains it.
         if (state_n != KILL) addr_q <= pc_n;
         if (buf_load) begin
            buf_pc   <= pc_f;
            buf_inst <= imem.imem_rdata;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_dx    <= '0;
         inst_dx  <= NOP_INST;
         valid_dx <= 1'b0;
      end else if (flush_dx || br_taken) begin
         pc_dx    <= pc_f;
         inst_dx  <= NOP_INST;
         valid_dx <= 1'b0;
      end else if (!stall_dx) begin
         pc_dx    <= cand_pc;
         inst_dx  <= cand_inst;
         valid_dx <= cand_valid;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed scoreboard bench for fetch_unit
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] KEY = 32'hA5A5_0000;

   typedef struct {
      logic        v;
      logic [31:0] pc;
      logic [31:0] inst;
      string       tag;
   } dx_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall_if = 1'b0, stall_dx = 1'b0, flush_dx = 1'b0, br_taken = 1'b0;
   logic [31:0] br_target = '0;
   logic [31:0] pc_dx, inst_dx;
   logic        valid_dx;
   int          checks = 0;
   int          errors = 0;
   dx_t         sb[$];

   fetch_unit_if #(.XLEN(32)) imem ();

   fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .NOP_INST(32'h0000_0013)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .stall_if (stall_if),
      .stall_dx (stall_dx),
      .flush_dx (flush_dx),
      .br_taken (br_taken),
      .br_target(br_target),
      .imem     (imem.master),
      .pc_dx    (pc_dx),
      .inst_dx  (inst_dx),
      .valid_dx (valid_dx)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_bus(input string tag, input logic req, input logic [31:0] addr);
      chk({tag, ".req"}, {31'b0, imem.imem_req}, {31'b0, req});
      if (req) chk({tag, ".addr"}, imem.imem_addr, addr);
   endtask

   // Called at a falling edge: drive one cycle of stimulus, push the DX
   // contents expected after the next rising edge, then pop and compare.
   task automatic step(input logic ack, input logic sif, input logic sdx, input logic fl,
                       input logic br, input logic [31:0] tgt,
                       input logic ev, input logic [31:0] epc, input string tag);
      dx_t e, o;
      imem.imem_ack   = ack;
      imem.imem_rdata = ack ? (imem.imem_addr ^ KEY) : 32'hDEAD_BEEF;
      stall_if  = sif;
      stall_dx  = sdx;
      flush_dx  = fl;
      br_taken  = br;
      br_target = tgt;
      e.v = ev; e.pc = epc; e.inst = ev ? (epc ^ KEY) : NOP; e.tag = tag;
      sb.push_back(e);
      @(posedge clk);
      #1;
      o = sb.pop_front();
      chk({o.tag, ".valid"}, {31'b0, valid_dx}, {31'b0, o.v});
      chk({o.tag, ".inst"}, inst_dx, o.inst);
      if (o.v) chk({o.tag, ".pc"}, pc_dx, o.pc);
      @(negedge clk);
   endtask

   initial begin
      imem.imem_ack   = 1'b0;
      imem.imem_rdata = '0;
      repeat (2) @(negedge clk);
      chk_bus("rst", 1'b0, 32'h0);
      chk("rst.addr", imem.imem_addr, 32'h0);
      chk("rst.valid", {31'b0, valid_dx}, 32'h0);
      chk("rst.inst", inst_dx, NOP);
      chk("rst.pc", pc_dx, 32'h0);

      // release with a stray ack while req is still low: must be ignored
      rst_n = 1'b1;
      step(1, 0, 0, 0, 0, 0, 0, 0, "stray_ack");

      // zero-wait fetch
      chk_bus("zw0", 1, 32'h0);  step(1, 0, 0, 0, 0, 0, 1, 32'h0, "zw0");
      chk_bus("zw4", 1, 32'h4);  step(1, 0, 0, 0, 0, 0, 1, 32'h4, "zw4");
      chk_bus("zw8", 1, 32'h8);  step(1, 0, 0, 0, 0, 0, 1, 32'h8, "zw8");

      // wait states at 0xC
      for (int i = 0; i < 3; i++) begin
         chk_bus("ws_hold", 1, 32'hC);
         step(0, 0, 0, 0, 0, 0, 0, 0, "ws_bubble");
      end
      chk_bus("ws_ack", 1, 32'hC); step(1, 0, 0, 0, 0, 0, 1, 32'hC, "ws_ack");

      // load-use: stall_if+flush_dx while 0x10 returns
      chk_bus("lu", 1, 32'h10);  step(1, 1, 0, 1, 0, 0, 0, 0, "lu_bubble");
      chk_bus("lu_hold", 0, 0);  step(1, 0, 0, 0, 0, 0, 1, 32'h10, "lu_release");
      chk_bus("lu_next", 1, 32'h14);

      // redirect while 0x14 is in flight
      step(0, 0, 0, 0, 1, 32'h103, 0, 0, "rd_br");
      chk_bus("rd_kill0", 1, 32'h14); step(0, 0, 0, 0, 0, 0, 0, 0, "rd_wait");
      chk_bus("rd_kill1", 1, 32'h14); step(1, 0, 0, 0, 0, 0, 0, 0, "rd_drop");
      chk_bus("rd_new", 1, 32'h100);  step(1, 0, 0, 0, 0, 0, 1, 32'h100, "rd_100");

      // redirect out of HOLD, then wrap past the top of memory
      chk_bus("hb", 1, 32'h104);      step(1, 1, 0, 0, 0, 0, 0, 0, "hb_capture");
      chk_bus("hb_hold", 0, 0);       step(1, 1, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, "hb_br");
      chk_bus("wrap_hi", 1, 32'hFFFF_FFFC); step(1, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, "wrap_hi");
      chk_bus("wrap_lo", 1, 32'h0);   step(1, 0, 0, 0, 0, 0, 1, 32'h0, "wrap_lo");

      // stall_if with stall_dx: DX keeps 0x0 while 0x4 is buffered
      chk_bus("sd", 1, 32'h4);        step(1, 1, 1, 0, 0, 0, 1, 32'h0, "sd_hold");
      chk_bus("sd_hold", 0, 0);       step(0, 0, 0, 0, 0, 0, 1, 32'h4, "sd_release");

      // asynchronous reset in the middle of the 0x8 request
      chk_bus("mr", 1, 32'h8);
      imem.imem_ack = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("mr.req", {31'b0, imem.imem_req}, 32'h0);
      chk("mr.valid", {31'b0, valid_dx}, 32'h0);
      chk("mr.inst", inst_dx, NOP);
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 0, 0, 0, 0, 0, 0, 0, "mr_stray");
      chk_bus("mr_first", 1, 32'h0);  step(1, 0, 0, 0, 0, 0, 1, 32'h0, "mr_first");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
